// File: rtl/m_cnt_checker_if.sv
// Sample stream and monitor outputs of the counter checker.
// The checker uses the slave modport; the upstream side uses master.
interface m_cnt_checker_if #(
  parameter int WIDTH = 2,
  parameter int ERRW  = 8
);
  logic             w_valid;
  logic [WIDTH-1:0] w_cnt;
  logic             w_clr;
  logic             w_locked;
  logic             w_err;
  logic [ERRW-1:0]  w_err_cnt;
  logic [1:0]       w_state;
  logic [WIDTH-1:0] w_expect;

  modport master (
    output w_valid, w_cnt, w_clr,
    input  w_locked, w_err, w_err_cnt, w_state, w_expect
  );

  modport slave (
    input  w_valid, w_cnt, w_clr,
    output w_locked, w_err, w_err_cnt, w_state, w_expect
  );
endinterface

// File: rtl/m_cnt_checker.sv
// Checks that a free-running count stream increments by one (mod 2^WIDTH),
// acquiring lock after a clean run and counting mismatches once locked.
module m_cnt_checker #(
  parameter int WIDTH      = 2,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int ERRW       = 8
) (
  input  logic              w_clk,
  input  logic              w_rst,
  m_cnt_checker_if.slave    bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    UNUSED = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] expect_q, expect_nxt;
  logic [3:0]       good, good_nxt;
  logic [3:0]       bad, bad_nxt;
  logic             err_q, mis;
  logic [ERRW-1:0]  err_cnt, err_cnt_nxt;
  logic             locked_q;

  logic             match;
  logic [WIDTH-1:0] cnt_inc;
  logic [3:0]       good_inc, bad_inc;

  // The wrap from all-ones to zero falls out of the WIDTH-bit add.
  assign cnt_inc  = bus.w_cnt + 1'b1;
  assign match    = (bus.w_cnt == expect_q);
  assign good_inc = good + 4'd1;
  assign bad_inc  = bad + 4'd1;

  // NOTE: every next-state signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    expect_nxt = expect_q;
    good_nxt   = good;
    bad_nxt    = bad;
    mis        = 1'b0;
    case (state)
      HUNT: if (bus.w_valid) begin
        expect_nxt = cnt_inc;
        good_nxt   = 4'd0;
        state_nxt  = SYNC;
      end
      SYNC: if (bus.w_valid) begin
        expect_nxt = cnt_inc;
        if (match) begin
          good_nxt = good_inc;
          if (good_inc == 4'(LOCK_CNT)) begin
            state_nxt = LOCKED;
            bad_nxt   = 4'd0;
          end
        end else begin
          good_nxt = 4'd0;
        end
      end
      LOCKED: if (bus.w_valid) begin
        expect_nxt = cnt_inc;
        if (match) begin
          bad_nxt = 4'd0;
        end else begin
          mis     = 1'b1;
          bad_nxt = bad_inc;
          if (bad_inc == 4'(UNLOCK_CNT)) begin
            state_nxt = HUNT;
            good_nxt  = 4'd0;
            bad_nxt   = 4'd0;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // A clear in the same cycle as a counted mismatch leaves exactly that one.
  always_comb begin
    err_cnt_nxt = err_cnt;
    if (bus.w_clr)
      err_cnt_nxt = ERRW'(mis);
    else if (mis && (err_cnt != '1))
      err_cnt_nxt = err_cnt + 1'b1;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state    <= HUNT;
      expect_q <= '0;
      good     <= 4'd0;
      bad      <= 4'd0;
      err_q    <= 1'b0;
      err_cnt  <= '0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      expect_q <= expect_nxt;
      good     <= good_nxt;
      bad      <= bad_nxt;
      err_q    <= mis;
      err_cnt  <= err_cnt_nxt;
      locked_q <= (state_nxt == LOCKED);
    end
  end

  assign bus.w_locked  = locked_q;
  assign bus.w_err     = err_q;
  assign bus.w_err_cnt = err_cnt;
  assign bus.w_state   = state;
  assign bus.w_expect  = expect_q;

endmodule

// File: tb/tb_m_cnt_checker.sv
// Directed bench for m_cnt_checker: a vector table for the main sequences
// plus hand-written async-reset and error-counter saturation sequences.
module tb_m_cnt_checker;

  logic w_clk = 1'b0;
  logic w_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  m_cnt_checker_if #(.WIDTH(2), .ERRW(8)) bus ();

  m_cnt_checker #(
    .WIDTH(2), .LOCK_CNT(4), .UNLOCK_CNT(2), .ERRW(8)
  ) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus.slave)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic       v;
    logic [1:0] c;
    logic       clr;
    logic [1:0] st;
    logic       lk;
    logic       er;
    logic [7:0] ec;
    logic [1:0] ex;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [1:0] c, input logic clr,
                     input logic [1:0] st, input logic lk, input logic er,
                     input logic [7:0] ec, input logic [1:0] ex);
    vec_t t;
    t.v = v; t.c = c; t.clr = clr;
    t.st = st; t.lk = lk; t.er = er; t.ec = ec; t.ex = ex;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [1:0] c, input logic clr);
    @(negedge w_clk);
    bus.w_valid = v;
    bus.w_cnt   = c;
    bus.w_clr   = clr;
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] e;
    logic [1:0] c;
    int         ec_model;

    bus.w_valid = 1'b0;
    bus.w_cnt   = 2'd0;
    bus.w_clr   = 1'b0;

    // lock on 1,2,3,0,1
    add(1, 1, 0, 1, 0, 0, 0, 2);
    add(1, 2, 0, 1, 0, 0, 0, 3);
    add(1, 3, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 1);
    add(1, 1, 0, 2, 1, 0, 0, 2);
    // run through the 3->0 wrap while locked
    add(1, 2, 0, 2, 1, 0, 0, 3);
    add(1, 3, 0, 2, 1, 0, 0, 0);
    add(1, 0, 0, 2, 1, 0, 0, 1);
    add(1, 1, 0, 2, 1, 0, 0, 2);
    add(1, 2, 0, 2, 1, 0, 0, 3);
    add(1, 3, 0, 2, 1, 0, 0, 0);
    // single mismatch then recovery
    add(1, 0, 0, 2, 1, 0, 0, 1);
    add(1, 1, 0, 2, 1, 0, 0, 2);
    add(1, 3, 0, 2, 1, 1, 1, 0);
    add(1, 0, 0, 2, 1, 0, 1, 1);
    // two consecutive mismatches drop to HUNT; seed + 4 matches relock
    add(1, 3, 0, 2, 1, 1, 2, 0);
    add(1, 3, 0, 0, 0, 1, 3, 0);
    add(1, 0, 0, 1, 0, 0, 3, 1);
    add(1, 1, 0, 1, 0, 0, 3, 2);
    add(1, 2, 0, 1, 0, 0, 3, 3);
    add(1, 3, 0, 1, 0, 0, 3, 0);
    add(1, 0, 0, 2, 1, 0, 3, 1);
    // invalid cycles hold everything despite a mismatching w_cnt
    add(0, 3, 0, 2, 1, 0, 3, 1);
    add(0, 3, 0, 2, 1, 0, 3, 1);
    add(0, 3, 0, 2, 1, 0, 3, 1);
    add(1, 1, 0, 2, 1, 0, 3, 2);
    // bring err_cnt to 5 with isolated mismatches, then clear
    add(1, 0, 0, 2, 1, 1, 4, 1);
    add(1, 1, 0, 2, 1, 0, 4, 2);
    add(1, 0, 0, 2, 1, 1, 5, 1);
    add(1, 1, 0, 2, 1, 0, 5, 2);
    add(1, 3, 1, 2, 1, 1, 1, 0);
    add(0, 0, 1, 2, 1, 0, 0, 0);
    add(1, 0, 0, 2, 1, 0, 0, 1);

    // reset state, checked while reset is held
    repeat (2) @(posedge w_clk);
    #1;
    check("reset state",   32'(bus.w_state),   0);
    check("reset locked",  32'(bus.w_locked),  0);
    check("reset err",     32'(bus.w_err),     0);
    check("reset err_cnt", 32'(bus.w_err_cnt), 0);
    check("reset expect",  32'(bus.w_expect),  0);
    @(negedge w_clk);
    w_rst = 1'b0;

    // idle cycle after release must stay in HUNT
    step(0, 2'd2, 0);
    check("idle hunt state", 32'(bus.w_state), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].c, vecs[i].clr);
      check($sformatf("vec%0d state", i),   32'(bus.w_state),   32'(vecs[i].st));
      check($sformatf("vec%0d locked", i),  32'(bus.w_locked),  32'(vecs[i].lk));
      check($sformatf("vec%0d err", i),     32'(bus.w_err),     32'(vecs[i].er));
      check($sformatf("vec%0d err_cnt", i), 32'(bus.w_err_cnt), 32'(vecs[i].ec));
      check($sformatf("vec%0d expect", i),  32'(bus.w_expect),  32'(vecs[i].ex));
    end

    // async reset between clock edges takes effect immediately
    @(negedge w_clk);
    bus.w_valid = 1'b0;
    #2;
    w_rst = 1'b1;
    #1;
    check("async rst locked",  32'(bus.w_locked),  0);
    check("async rst state",   32'(bus.w_state),   0);
    check("async rst err_cnt", 32'(bus.w_err_cnt), 0);
    check("async rst expect",  32'(bus.w_expect),  0);
    @(negedge w_clk);
    w_rst = 1'b0;

    // saturation: lock, then alternate mismatch/match well past 255 errors
    step(1, 2'd0, 0);
    step(1, 2'd1, 0);
    step(1, 2'd2, 0);
    step(1, 2'd3, 0);
    step(1, 2'd0, 0);
    check("sat relock", 32'(bus.w_locked), 1);
    e = 2'd1;
    ec_model = 0;
    for (int n = 0; n < 260; n++) begin
      c = e + 2'd1;
      step(1, c, 0);
      ec_model = (ec_model < 255) ? ec_model + 1 : 255;
      if (n >= 253) begin
        check($sformatf("sat%0d err", n),     32'(bus.w_err),     1);
        check($sformatf("sat%0d err_cnt", n), 32'(bus.w_err_cnt), 32'(ec_model));
      end
      e = c + 2'd1;
      step(1, e, 0);
      e = e + 2'd1;
    end
    check("sat final err_cnt", 32'(bus.w_err_cnt), 255);
    check("sat final locked",  32'(bus.w_locked),  1);
    check("sat final err",     32'(bus.w_err),     0);
    check("sat final expect",  32'(bus.w_expect),  32'(e));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_cnt_checker.md
Name: m_cnt_checker

Overview:
Receiving end of the free-running counter stream produced by the counter block. It samples the incoming count and checks that each valid sample equals the previous one plus 1, modulo 2^WIDTH. It acquires lock after a run of consecutive correct samples, counts sequence errors, and drops lock after repeated mismatches. It sits downstream of the counter as a self-check and monitor block.

Parameters:
WIDTH, 2, width of the monitored count
LOCK_CNT, 4, consecutive matching samples after the seed sample required to lock (1..15)
UNLOCK_CNT, 2, consecutive mismatches while locked that force return to hunt (1..15)
ERRW, 8, width of the error counter

Ports:
w_clk  input  1  clock, all state changes on posedge
w_rst  input  1  asynchronous, active-high reset
w_valid  input  1  w_cnt is a valid sample this cycle
w_cnt  input  WIDTH  incoming count value
w_clr  input  1  synchronous clear of w_err_cnt
w_locked  output  1  high while in LOCKED
w_err  output  1  one-cycle pulse on each counted mismatch
w_err_cnt  output  ERRW  saturating count of mismatches
w_state  output  2  current state: 0=HUNT, 1=SYNC, 2=LOCKED
w_expect  output  WIDTH  next expected count value

Behaviour:
- Reset (async, w_rst=1) immediately clears all of the following: state=HUNT, expect=0, good=0, bad=0, w_err=0, w_err_cnt=0, w_locked=0. Reset asserted mid-operation takes effect without waiting for a clock edge.
- All outputs are registered. A sample on edge N is reflected on the outputs after edge N.
- Next expected value = (sample + 1) mod 2^WIDTH. The value 2^WIDTH-1 wraps to 0, and this wrap is never an error.
- w_valid=0: state, expect, good and bad all hold. w_err=0. w_cnt is ignored.
- HUNT, on a valid sample: expect<=cnt+1, good<=0, go to SYNC.
- SYNC, valid and cnt==expect: expect<=cnt+1, good<=good+1. If good+1==LOCK_CNT, go to LOCKED and set bad<=0.
- SYNC, valid and mismatch: re-seed with expect<=cnt+1 and good<=0. Stay in SYNC. No error is counted.
- LOCKED, valid and match: expect<=cnt+1, bad<=0.
- LOCKED, valid and mismatch: w_err<=1 for one cycle and w_err_cnt increments (saturating). expect<=cnt+1 (realign to the received value) and bad<=bad+1. If bad+1==UNLOCK_CNT, go to HUNT with good<=0 and bad<=0.
- w_err is 0 in every cycle without a counted mismatch.
- w_err_cnt saturates at all-ones and never wraps.
- w_clr=1 clears w_err_cnt to 0. If w_clr and a counted mismatch occur in the same cycle, w_err_cnt<=1.
- w_locked is (state==LOCKED) and is updated on the same edge as the state change.
- Unused state encoding 3 recovers to HUNT on the next edge.

Test Plan (WIDTH=2, LOCK_CNT=4, UNLOCK_CNT=2, ERRW=8):
1. Reset, release, then feed valid 1,2,3,0,1 on consecutive edges -> state goes HUNT->SYNC after the first sample, LOCKED after the fifth; w_locked=1; w_expect=2; w_err_cnt=0.
2. While locked, continue 2,3,0,1,2,3 -> passes through the 3->0 wrap with w_err never asserted and w_locked held at 1.
3. Locked with expect=2, feed 3 then 0 -> w_err pulses one cycle, w_err_cnt=1, w_expect=0 after the 3; the 0 matches, bad clears, still LOCKED.
4. Locked with expect=1, feed 3 then 3 -> two w_err pulses, w_err_cnt=2, state=HUNT, w_locked=0. The next 4 valid samples alone do not relock; relock needs the seed sample plus 4 matches.
5. Locked, hold w_valid=0 for 3 cycles with w_cnt=3 while expect=1 -> no error and no change; resume with valid 1 -> match.
6. Locked with w_err_cnt=5: assert w_clr together with a mismatch -> w_err_cnt=1. Then assert w_rst between clock edges -> w_locked=0, w_state=0, w_err_cnt=0 before the next posedge.
